// File: rtl/imem_program_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory while
// holding the core in reset, appends a NOP terminator when room allows, then releases the core.
module imem_program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count,
    output logic [3:0]            fsm_state
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LEN_LO = 4'd1;
    localparam logic [3:0] LEN_HI = 4'd2;
    localparam logic [3:0] CHECK  = 4'd3;
    localparam logic [3:0] BYTE   = 4'd4;
    localparam logic [3:0] WRITE  = 4'd5;
    localparam logic [3:0] TERM   = 4'd6;
    localparam logic [3:0] RUN    = 4'd7;
    localparam logic [3:0] ERROR  = 4'd8;

    logic [3:0]  state;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] shreg;
    logic        accept;
    logic        can_start;
    logic        last_word;
    logic [16:0] len_ext;

    // Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
    // in_ready is registered and high only in LEN_LO, LEN_HI and BYTE.
    assign accept    = in_valid && in_ready;
    assign can_start = start && ((state == IDLE) || (state == RUN) || (state == ERROR));
    assign last_word = (word_count + 16'd1) == len;
    assign len_ext   = {1'b0, len};
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len        <= 16'd0;
            byte_idx   <= 2'd0;
            shreg      <= 24'd0;
            word_count <= 16'd0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (can_start) begin
                state      <= LEN_LO;
                in_ready   <= 1'b1;
                busy       <= 1'b1;
                done       <= 1'b0;
                error      <= 1'b0;
                core_reset <= 1'b1;
                word_count <= 16'd0;
                byte_idx   <= 2'd0;
                shreg      <= 24'd0;
            end else begin
                case (state)
                    LEN_LO: begin
                        if (accept) begin
                            len[7:0] <= in_data;
                            state    <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (accept) begin
                            len[15:8] <= in_data;
                            in_ready  <= 1'b0;
                            state     <= CHECK;
                        end
                    end
                    // One cycle to validate the full header before any data is taken.
                    CHECK: begin
                        if ((len == 16'd0) || (len_ext > DEPTH)) begin
                            state <= ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= BYTE;
                            in_ready <= 1'b1;
                        end
                    end
                    BYTE: begin
                        if (accept) begin
                            if (byte_idx == 2'd3) begin
                                state      <= WRITE;
                                in_ready   <= 1'b0;
                                imem_we    <= 1'b1;
                                imem_addr  <= word_count[ADDR_WIDTH-1:0];
                                imem_wdata <= {in_data, shreg};
                                byte_idx   <= 2'd0;
                            end else begin
                                shreg    <= {in_data, shreg[23:8]};
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                    end
                    WRITE: begin
                        word_count <= word_count + 16'd1;
                        if (last_word) begin
                            // A full memory leaves no slot for the terminator.
                            if (len_ext == DEPTH) begin
                                state      <= RUN;
                                core_reset <= 1'b0;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                            end else begin
                                state      <= TERM;
                                imem_we    <= 1'b1;
                                imem_addr  <= len[ADDR_WIDTH-1:0];
                                imem_wdata <= NOP;
                            end
                        end else begin
                            state    <= BYTE;
                            in_ready <= 1'b1;
                        end
                    end
                    TERM: begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                    end
                    IDLE, RUN, ERROR: begin
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized bench for imem_program_loader: a bench-owned memory, an expected write queue
// built from the stream rules, and latency expectations derived from the byte count.
module tb_imem_program_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int W     = AW + 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [15:0]   word_count;
    logic [3:0]    fsm_state;

    imem_program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error),
        .word_count(word_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] tb_mem [DEPTH];
    logic [31:0] img [DEPTH];
    logic [31:0] snap [DEPTH];
    int          we_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Memory side: every write must be the next one the stream rules predict.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) check("we_unexpected", 1, 0);
            else check("we_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
            tb_mem[imem_addr] = imem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("byte_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    // Full load of img[0..n-1]; called and returns at #1 after a rising edge.
    task automatic run_load(input int n, input int max_gap, input bit poke_start);
        bit expect_err;
        int c0;
        int c1;
        bit finished;
        logic [15:0] n16;
        expect_err = (n == 0) || (n > DEPTH);
        n16 = 16'(n);
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'hdead_beef;
        if (!expect_err) begin
            for (int i = 0; i < n; i++) exp_q.push_back({i[AW-1:0], img[i]});
            if (n < DEPTH) exp_q.push_back({n[AW-1:0], 32'h0000_0013});
        end
        we_count = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        check("ready_after_start", in_ready, 1);
        check("core_reset_loading", core_reset, 1);
        check("busy_loading", busy, 1);
        check("done_cleared", done, 0);
        check("error_cleared", error, 0);
        send_byte(n16[7:0], max_gap);
        send_byte(n16[15:8], max_gap);
        if (!expect_err) begin
            for (int i = 0; i < n; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (poke_start && i == 1 && b == 1) start = 1'b1;
                    send_byte(img[i][8*b +: 8], max_gap);
                    start = 1'b0;
                end
            end
        end
        finished = 1'b0;
        c1 = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done || error) begin
                finished = 1'b1;
                c1 = cyc;
                break;
            end
        end
        if (!finished) check("load_timeout", 0, 1);
        if (expect_err) begin
            check("error_set", error, 1);
            check("error_done", done, 0);
            check("error_core_reset", core_reset, 1);
            check("error_busy", busy, 0);
            if (max_gap == 0) check("error_latency", c1 - c0, 3);
            check("error_no_writes", we_count, 0);
        end else begin
            check("done_set", done, 1);
            check("core_released", core_reset, 0);
            check("busy_clear", busy, 0);
            check("error_clear", error, 0);
            check("word_count", word_count, n);
            if (max_gap == 0) check("load_latency", c1 - c0, (n < DEPTH) ? 4 + 5 * n : 3 + 5 * n);
            check("we_pulses", we_count, (n < DEPTH) ? n + 1 : n);
            check("exp_q_drained", exp_q.size(), 0);
            for (int i = 0; i < n; i++) check("mem_word", tb_mem[i], img[i]);
            if (n < DEPTH) check("mem_terminator", tb_mem[n], 32'h0000_0013);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic random_image(input int n);
        for (int i = 0; i < n; i++) img[i] = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) tick();
        check_reset_values("por");
        reset = 1'b0;
        repeat (2) tick();
        check("idle_no_ready", in_ready, 0);

        // Fibonacci image, no stalls
        img[0] = 32'h0050_0093;
        img[1] = 32'h0010_0113;
        img[2] = 32'h0020_81b3;
        run_load(3, 0, 1'b0);

        // Restart from RUN
        random_image(2);
        run_load(2, 0, 1'b0);

        // Bad headers, then recovery with N=1
        run_load(0, 0, 1'b0);
        run_load(DEPTH + 1, 0, 1'b0);
        random_image(1);
        run_load(1, 0, 1'b0);

        // Full memory, no terminator
        random_image(DEPTH);
        run_load(DEPTH, 0, 1'b0);

        // Same N=4 image without and with stalls
        random_image(4);
        run_load(4, 0, 1'b0);
        for (int i = 0; i < 5; i++) snap[i] = tb_mem[i];
        run_load(4, 5, 1'b0);
        for (int i = 0; i < 5; i++) check("stall_vs_nostall", tb_mem[i], snap[i]);

        // start during BYTE is ignored
        random_image(3);
        run_load(3, 0, 1'b1);

        // reset and start together from RUN: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_reset_values("reset_vs_start");
        repeat (3) tick();
        check("no_load_after_collision", in_ready, 0);

        // Reset after 6 bytes of an N=3 load
        random_image(3);
        tb_mem[0] = 32'hdead_beef;
        tb_mem[1] = 32'hcafe_f00d;
        exp_q.push_back({{AW{1'b0}}, img[0]});
        we_count = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'd3, 0);
        send_byte(8'd0, 0);
        for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("mid_reset");
        in_valid = 1'b1;
        in_data = img[1][7:0];
        repeat (10) tick();
        in_valid = 1'b0;
        check("mid_reset_idle", in_ready, 0);
        check("mid_reset_we_count", we_count, 1);
        check("mid_reset_word0", tb_mem[0], img[0]);
        check("mid_reset_word1_untouched", tb_mem[1], 32'hcafe_f00d);
        check("mid_reset_exp_q", exp_q.size(), 0);
        exp_q.delete();

        // Random loads with random gaps
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(DEPTH, 1);
            random_image(n);
            run_load(n, $urandom_range(3, 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
